// File: rtl/rom_scan_ctrl.sv
// Scan controller for a small combinational lookup ROM: walks an address window and reports
// sum/max/min with a one-cycle completion pulse. Optional wrap-around: ROM_SCAN_WRAP_EN.
module rom_scan_ctrl #(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic [AW-1:0] Dir_ini,
  input  logic [7:0]    Longitud,
  output logic [AW-1:0] Dir,
  input  logic [DW-1:0] Dato_s,
  output logic          Ocupado,
  output logic          Listo,
  output logic          Error,
  output logic [15:0]   Suma,
  output logic [DW-1:0] Maximo,
  output logic [DW-1:0] Minimo
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] dir_q, dir_d, dir_nxt;
  logic [7:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          listo_q, listo_d;
  logic          error_q, error_d;
  logic [15:0]   sum_q, sum_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] min_q, min_d;
  logic          req_bad;

`ifdef ROM_SCAN_WRAP_EN
  assign dir_nxt = (dir_q == AW'(DEPTH - 1)) ? '0 : dir_q + AW'(1);
  assign req_bad = (Longitud == 8'd0) || (Dir_ini >= AW'(DEPTH));
`else
  logic [AW:0] win_end;

  // One extra bit so the window end cannot overflow before the compare.
  assign win_end = (AW + 1)'(Dir_ini) + (AW + 1)'(Longitud);
  assign dir_nxt = dir_q + AW'(1);
  assign req_bad = (Longitud == 8'd0) || (Dir_ini >= AW'(DEPTH)) ||
                   (win_end > (AW + 1)'(DEPTH));
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    listo_d = 1'b0;
    error_d = error_q;
    sum_d   = sum_q;
    max_d   = max_q;
    min_d   = min_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          sum_d   = '0;
          max_d   = '0;
          min_d   = '1;
          error_d = req_bad;
          if (req_bad) begin
            // Rejected requests complete on the sampling edge without touching the ROM.
            listo_d = 1'b1;
            state_d = StDone;
          end else begin
            dir_d   = Dir_ini;
            cnt_d   = Longitud;
            busy_d  = 1'b1;
            state_d = StScan;
          end
        end
      end
      StScan: begin
        sum_d = sum_q + 16'(Dato_s);
        if (Dato_s > max_q) max_d = Dato_s;
        if (Dato_s < min_q) min_d = Dato_s;
        dir_d = dir_nxt;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          busy_d  = 1'b0;
          listo_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dir_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      listo_q <= 1'b0;
      error_q <= 1'b0;
      sum_q   <= '0;
      max_q   <= '0;
      min_q   <= '1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      listo_q <= listo_d;
      error_q <= error_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      min_q   <= min_d;
    end
  end

  assign Dir     = dir_q;
  assign Ocupado = busy_q;
  assign Listo   = listo_q;
  assign Error   = error_q;
  assign Suma    = sum_q;
  assign Maximo  = max_q;
  assign Minimo  = min_q;

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Directed bench for rom_scan_ctrl with a behavioural 12-entry ROM and hand-computed results.
module tb_rom_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  dir_ini;
  logic [7:0]  longitud;
  logic [7:0]  dir;
  logic [7:0]  dato_s;
  logic        ocupado;
  logic        listo;
  logic        error;
  logic [15:0] suma;
  logic [7:0]  maximo;
  logic [7:0]  minimo;

  int n_total = 0;
  int n_bad   = 0;

  rom_scan_ctrl #(
    .DEPTH(12),
    .AW   (8),
    .DW   (8)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .Start   (start),
    .Dir_ini (dir_ini),
    .Longitud(longitud),
    .Dir     (dir),
    .Dato_s  (dato_s),
    .Ocupado (ocupado),
    .Listo   (listo),
    .Error   (error),
    .Suma    (suma),
    .Maximo  (maximo),
    .Minimo  (minimo)
  );

  function automatic logic [7:0] rom_word(input logic [7:0] a);
    case (a)
      8'd0:    rom_word = 8'd90;
      8'd1:    rom_word = 8'd80;
      8'd2:    rom_word = 8'd40;
      8'd3:    rom_word = 8'd60;
      8'd4:    rom_word = 8'd50;
      8'd5:    rom_word = 8'd40;
      8'd6:    rom_word = 8'd30;
      8'd7:    rom_word = 8'd20;
      8'd8:    rom_word = 8'd10;
      8'd9:    rom_word = 8'd100;
      8'd10:   rom_word = 8'd101;
      8'd11:   rom_word = 8'd102;
      default: rom_word = 8'd0;
    endcase
  endfunction

  assign dato_s = rom_word(dir);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] ini, input logic [7:0] len);
    @(negedge clk);
    start    = 1'b1;
    dir_ini  = ini;
    longitud = len;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic scan_valid(input logic [7:0] ini, input logic [7:0] len,
                            input logic [15:0] e_sum, input logic [7:0] e_max,
                            input logic [7:0] e_min);
    pulse_start(ini, len);
    check_eq("e0_ocupado", 32'(ocupado), 32'd1);
    check_eq("e0_error", 32'(error), 32'd0);
    check_eq("e0_dir", 32'(dir), 32'(ini));
    check_eq("e0_suma_clr", 32'(suma), 32'd0);
    for (int k = 1; k < int'(len); k++) begin
      @(posedge clk);
      #1;
      check_eq("scan_dir", 32'(dir), 32'((int'(ini) + k) % 12));
      check_eq("scan_listo", 32'(listo), 32'd0);
      check_eq("scan_ocupado", 32'(ocupado), 32'd1);
    end
    @(posedge clk);
    #1;
    check_eq("end_listo", 32'(listo), 32'd1);
    check_eq("end_ocupado", 32'(ocupado), 32'd0);
    check_eq("end_suma", 32'(suma), 32'(e_sum));
    check_eq("end_maximo", 32'(maximo), 32'(e_max));
    check_eq("end_minimo", 32'(minimo), 32'(e_min));
    check_eq("end_error", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    check_eq("post_listo", 32'(listo), 32'd0);
    check_eq("post_suma_hold", 32'(suma), 32'(e_sum));
  endtask

  task automatic scan_invalid(input logic [7:0] ini, input logic [7:0] len,
                              input logic [7:0] e_dir);
    pulse_start(ini, len);
    check_eq("rej_error", 32'(error), 32'd1);
    check_eq("rej_listo", 32'(listo), 32'd1);
    check_eq("rej_ocupado", 32'(ocupado), 32'd0);
    check_eq("rej_dir_hold", 32'(dir), 32'(e_dir));
    check_eq("rej_suma", 32'(suma), 32'd0);
    check_eq("rej_maximo", 32'(maximo), 32'd0);
    check_eq("rej_minimo", 32'(minimo), 32'hFF);
    @(posedge clk);
    #1;
    check_eq("rej_listo_drop", 32'(listo), 32'd0);
    check_eq("rej_error_hold", 32'(error), 32'd1);
    check_eq("rej_ocupado2", 32'(ocupado), 32'd0);
    check_eq("rej_dir_hold2", 32'(dir), 32'(e_dir));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_dir", 32'(dir), 32'd0);
    check_eq("rst_ocupado", 32'(ocupado), 32'd0);
    check_eq("rst_listo", 32'(listo), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_suma", 32'(suma), 32'd0);
    check_eq("rst_maximo", 32'(maximo), 32'd0);
    check_eq("rst_minimo", 32'(minimo), 32'hFF);
  endtask

  logic [7:0] dir_after;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dir_ini  = 8'd0;
    longitud = 8'd0;
    #2;
    check_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    scan_valid(8'd0, 8'd3, 16'd210, 8'd90, 8'd40);
    check_eq("dir_after_3", 32'(dir), 32'd3);
    scan_valid(8'd0, 8'd12, 16'd723, 8'd102, 8'd10);
    scan_valid(8'd8, 8'd4, 16'd313, 8'd102, 8'd10);

`ifdef ROM_SCAN_WRAP_EN
    scan_valid(8'd10, 8'd4, 16'd373, 8'd102, 8'd80);
    dir_after = 8'd2;
`else
    scan_invalid(8'd10, 8'd4, 8'd12);
    dir_after = 8'd12;
`endif
    check_eq("dir_after_win", 32'(dir), 32'(dir_after));

    scan_invalid(8'd0, 8'd0, dir_after);
    scan_invalid(8'd12, 8'd1, dir_after);
    scan_valid(8'd0, 8'd3, 16'd210, 8'd90, 8'd40);

    // Abort a 6-word scan: ignored Start at E0+2, then reset just before E0+3.
    pulse_start(8'd0, 8'd6);
    @(posedge clk);
    #1;
    check_eq("abort_e1_dir", 32'(dir), 32'd1);
    @(negedge clk);
    start    = 1'b1;
    dir_ini  = 8'd5;
    longitud = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("ign_start_dir", 32'(dir), 32'd2);
    check_eq("ign_start_ocupado", 32'(ocupado), 32'd1);
    check_eq("ign_start_suma", 32'(suma), 32'd170);
    #5;
    rst = 1'b1;
    #1;
    check_reset_vals();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_eq("abort_no_listo", 32'(listo), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("abort_idle_listo", 32'(listo), 32'd0);
      check_eq("abort_idle_ocupado", 32'(ocupado), 32'd0);
    end
    scan_valid(8'd2, 8'd3, 16'd150, 8'd60, 8'd40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
